// File: rtl/cfs_apb_reg_slave_if.sv
// APB bus bundle between a requester (master) and the cfs_apb_reg_slave completer.
// Clock and reset are carried as plain ports on the attached modules.
interface cfs_apb_reg_slave_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr,
        output pwrite,
        output psel,
        output penable,
        output pwdata,
        input  prdata,
        input  pready,
        input  pslverr
    );

    modport slave (
        input  paddr,
        input  pwrite,
        input  psel,
        input  penable,
        input  pwdata,
        output prdata,
        output pready,
        output pslverr
    );

endinterface

// File: rtl/cfs_apb_reg_slave.sv
// APB completer with a four-word register bank (CTRL, STATUS, SCRATCH, ID),
// programmable access-phase wait states and pslverr for bad or read-only accesses.
module cfs_apb_reg_slave #(
    parameter int unsigned          ADDR_WIDTH  = 16,
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hCF5A_0001
) (
    input  logic                  pclk,
    input  logic                  preset,
    cfs_apb_reg_slave_if.slave    apb,
    output logic [DATA_WIDTH-1:0] ctrl_o
);

    localparam logic [3:0]  WaitMax = 4'(WAIT_CYCLES);
    localparam logic [15:0] CntMax  = 16'hFFFF;

    localparam logic [1:0] IdxCtrl    = 2'd0;
    localparam logic [1:0] IdxStatus  = 2'd1;
    localparam logic [1:0] IdxScratch = 2'd2;
    localparam logic [1:0] IdxId      = 2'd3;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic [15:0]           err_cnt_q, err_cnt_d;

    logic [1:0]            reg_idx;
    logic                  addr_lo_err;
    logic                  addr_hi_err;
    logic                  ro_err;
    logic                  access_err;
    logic                  complete;
    logic [DATA_WIDTH-1:0] rd_val;

    // Address decode and error classification work on the live bus inputs.
    assign reg_idx     = apb.paddr[3:2];
    assign addr_lo_err = apb.paddr[1:0] != 2'b00;
    assign addr_hi_err = apb.paddr[ADDR_WIDTH-1:4] != '0;
    assign ro_err      = apb.pwrite && ((reg_idx == IdxStatus) || (reg_idx == IdxId));
    assign access_err  = addr_lo_err || addr_hi_err || ro_err;

    assign complete = (state_q == StAccess) && apb.psel && (wait_cnt_q == WaitMax);

    always_comb begin
        rd_val = '0;
        unique case (reg_idx)
            IdxCtrl:    rd_val = ctrl_q;
            IdxStatus:  rd_val = {wr_cnt_q, err_cnt_q};
            IdxScratch: rd_val = scratch_q;
            IdxId:      rd_val = ID_VALUE;
            default:    rd_val = '0;
        endcase
    end

    assign apb.pready  = complete;
    assign apb.pslverr = complete && access_err;
    assign apb.prdata  = (complete && !access_err && !apb.pwrite) ? rd_val : '0;
    assign ctrl_o      = ctrl_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctrl_d     = ctrl_q;
        scratch_d  = scratch_q;
        wr_cnt_d   = wr_cnt_q;
        err_cnt_d  = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                // An access phase with no preceding setup phase is ignored.
                if (apb.psel && !apb.penable) begin
                    state_d    = StAccess;
                    wait_cnt_d = 4'd0;
                end
            end
            StAccess: begin
                if (!apb.psel) begin
                    state_d    = StIdle;
                    wait_cnt_d = 4'd0;
                end else if (wait_cnt_q < WaitMax) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end else begin
                    state_d    = StIdle;
                    wait_cnt_d = 4'd0;
                    if (access_err) begin
                        if (err_cnt_q != CntMax) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end else if (apb.pwrite) begin
                        if (wr_cnt_q != CntMax) begin
                            wr_cnt_d = wr_cnt_q + 16'd1;
                        end
                        if (reg_idx == IdxCtrl) begin
                            ctrl_d = apb.pwdata;
                        end
                        if (reg_idx == IdxScratch) begin
                            scratch_d = apb.pwdata;
                        end
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            ctrl_q     <= '0;
            scratch_q  <= '0;
            wr_cnt_q   <= 16'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ctrl_q     <= ctrl_d;
            scratch_q  <= scratch_d;
            wr_cnt_q   <= wr_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_cfs_apb_reg_slave.sv
// Scoreboard bench for cfs_apb_reg_slave: three instances with 0, 3 and 2 wait states,
// a shared APB driver, and a monitor that checks every completion against a register model.
module tb_cfs_apb_reg_slave;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic [2:0]    rst;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] pwdata;
    int            act;

    logic [DW-1:0] ctrl0, ctrl1, ctrl2;
    logic          mon_pready;
    logic          mon_pslverr;
    logic [DW-1:0] mon_prdata;
    logic [DW-1:0] mon_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] addr;
        logic        write;
    } exp_t;
    exp_t exp_q[$];

    // Register model, one slot per instance.
    logic [31:0] m_ctrl[3];
    logic [31:0] m_scratch[3];
    int          m_wr[3];
    int          m_err[3];

    always #5 pclk = ~pclk;

    cfs_apb_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    cfs_apb_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    cfs_apb_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    assign bus0.paddr   = paddr;
    assign bus0.pwrite  = pwrite;
    assign bus0.pwdata  = pwdata;
    assign bus0.psel    = psel && (act == 0);
    assign bus0.penable = penable;
    assign bus1.paddr   = paddr;
    assign bus1.pwrite  = pwrite;
    assign bus1.pwdata  = pwdata;
    assign bus1.psel    = psel && (act == 1);
    assign bus1.penable = penable;
    assign bus2.paddr   = paddr;
    assign bus2.pwrite  = pwrite;
    assign bus2.pwdata  = pwdata;
    assign bus2.psel    = psel && (act == 2);
    assign bus2.penable = penable;

    cfs_apb_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) u_dut0 (
        .pclk   (pclk),
        .preset (rst[0]),
        .apb    (bus0),
        .ctrl_o (ctrl0)
    );
    cfs_apb_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(3)) u_dut1 (
        .pclk   (pclk),
        .preset (rst[1]),
        .apb    (bus1),
        .ctrl_o (ctrl1)
    );
    cfs_apb_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) u_dut2 (
        .pclk   (pclk),
        .preset (rst[2]),
        .apb    (bus2),
        .ctrl_o (ctrl2)
    );

    always_comb begin
        mon_pready  = bus0.pready;
        mon_pslverr = bus0.pslverr;
        mon_prdata  = bus0.prdata;
        mon_ctrl    = ctrl0;
        case (act)
            1: begin
                mon_pready  = bus1.pready;
                mon_pslverr = bus1.pslverr;
                mon_prdata  = bus1.prdata;
                mon_ctrl    = ctrl1;
            end
            2: begin
                mon_pready  = bus2.pready;
                mon_pslverr = bus2.pslverr;
                mon_prdata  = bus2.prdata;
                mon_ctrl    = ctrl2;
            end
            default: ;
        endcase
    end

    function automatic int wait_of(input int k);
        case (k)
            1:       return 3;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s (inst %0d): got %h expected %h at %0t", name, act, got, want, $time);
        end
    endtask

    function automatic void model_reset(input int k);
        m_ctrl[k]    = 32'h0;
        m_scratch[k] = 32'h0;
        m_wr[k]      = 0;
        m_err[k]     = 0;
    endfunction

    // Behavioural register-map rules: returns the response and applies the side effects.
    function automatic void model(input int k, input logic [15:0] a, input logic w,
                                  input logic [31:0] d, output logic [31:0] rd,
                                  output logic err);
        err = (a % 4 != 0) || (a >= 16) || (w && (a == 4 || a == 12));
        rd  = 32'h0;
        if (err) begin
            m_err[k] = (m_err[k] < 65535) ? m_err[k] + 1 : 65535;
        end else if (w) begin
            m_wr[k] = (m_wr[k] < 65535) ? m_wr[k] + 1 : 65535;
            if (a == 0) m_ctrl[k] = d;
            if (a == 8) m_scratch[k] = d;
        end else begin
            case (a)
                16'h0:   rd = m_ctrl[k];
                16'h4:   rd = {16'(m_wr[k]), 16'(m_err[k])};
                16'h8:   rd = m_scratch[k];
                default: rd = 32'hCF5A_0001;
            endcase
        end
    endfunction

    // Issue one full transfer; the monitor checks the response, this task checks latency.
    task automatic xfer(input logic [15:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        int   n;
        bit   done;
        @(posedge pclk);
        #1;
        check("ctrl_o", mon_ctrl, m_ctrl[act]);
        model(act, a, w, d, e.rdata, e.err);
        e.addr  = a;
        e.write = w;
        exp_q.push_back(e);
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge pclk);
            n++;
            if (mon_pready) done = 1'b1;
        end
        check("latency", done ? 32'(n) : 32'hFFFF_FFFF, 32'(wait_of(act) + 1));
        if (!done && exp_q.size() > 0) void'(exp_q.pop_back());
    endtask

    task automatic idle(input int n);
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        check("ctrl_o_idle", mon_ctrl, m_ctrl[act]);
        repeat (n - 1) @(posedge pclk);
    endtask

    task automatic rand_run(input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 9))
                0, 4:    a = 16'h0;
                1:       a = 16'h4;
                2, 5:    a = 16'h8;
                3:       a = 16'hC;
                6:       a = 16'h2;
                7:       a = 16'h10;
                8:       a = 16'h13;
                default: a = 16'($urandom);
            endcase
            xfer(a, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
    endtask

    // Monitor: every pready pops one expected response; pready must never appear unbidden.
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (mon_pready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pready (inst %0d): got 1 expected 0 at %0t",
                             act, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("prdata", mon_prdata, e.rdata);
                    check("pslverr", 32'(mon_pslverr), 32'(e.err));
                end
            end else if (psel) begin
                check("prdata_idle", mon_prdata, 32'h0);
                check("pslverr_idle", 32'(mon_pslverr), 32'h0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 3'b111;
        psel    = 1'b0;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        act     = 0;
        for (int k = 0; k < 3; k++) model_reset(k);
        repeat (3) @(posedge pclk);
        #1;
        rst = 3'b000;
        @(negedge pclk);
        check("rst_pready0", 32'(bus0.pready), 32'h0);
        check("rst_pready1", 32'(bus1.pready), 32'h0);
        check("rst_pready2", 32'(bus2.pready), 32'h0);
        check("rst_prdata0", bus0.prdata, 32'h0);
        check("rst_pslverr1", 32'(bus1.pslverr), 32'h0);
        check("rst_ctrl0", ctrl0, 32'h0);
        check("rst_ctrl1", ctrl1, 32'h0);
        check("rst_ctrl2", ctrl2, 32'h0);

        // Zero wait states: directed write/read, STATUS, errors.
        act = 0;
        xfer(16'h0, 1'b1, 32'hDEAD_BEEF);
        xfer(16'h0, 1'b0, 32'h0);
        xfer(16'h4, 1'b0, 32'h0);
        idle(1);
        check("ctrl_o_deadbeef", ctrl0, 32'hDEAD_BEEF);
        // Access phase without setup must be ignored.
        @(posedge pclk);
        #1;
        psel    = 1'b1;
        penable = 1'b1;
        paddr   = 16'h0;
        pwrite  = 1'b1;
        pwdata  = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge pclk);
            check("no_setup_pready", 32'(mon_pready), 32'h0);
        end
        idle(1);
        xfer(16'h0, 1'b0, 32'h0);
        rand_run(60);

        // Wait states, back-to-back, errors, then reset mid-transfer.
        act = 1;
        idle(1);
        xfer(16'hC, 1'b0, 32'h0);
        xfer(16'h8, 1'b1, 32'h1234_5678);
        xfer(16'h8, 1'b0, 32'h0);
        xfer(16'h4, 1'b1, 32'hFFFF_FFFF);
        xfer(16'h2, 1'b0, 32'h0);
        xfer(16'h10, 1'b0, 32'h0);
        xfer(16'h4, 1'b0, 32'h0);
        xfer(16'h0, 1'b1, 32'hA5A5_A5A5);
        @(posedge pclk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = 16'h0;
        pwrite  = 1'b1;
        pwdata  = 32'h1111_1111;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(posedge pclk);
        #1;
        rst[1] = 1'b1;
        @(posedge pclk);
        #1;
        rst[1]  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        model_reset(1);
        check("midrst_pready", 32'(mon_pready), 32'h0);
        check("midrst_ctrl_o", ctrl1, 32'h0);
        xfer(16'h4, 1'b0, 32'h0);
        xfer(16'h0, 1'b0, 32'h0);
        rand_run(30);

        // Abort after one access cycle leaves everything untouched.
        act = 2;
        idle(1);
        xfer(16'h8, 1'b1, 32'h0BAD_F00D);
        @(posedge pclk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = 16'h8;
        pwrite  = 1'b1;
        pwdata  = 32'h5555_AAAA;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(negedge pclk);
        check("abort_pready", 32'(mon_pready), 32'h0);
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        xfer(16'h8, 1'b0, 32'h0);
        xfer(16'h4, 1'b0, 32'h0);
        rand_run(30);

        // Saturation: preload wr_cnt just below the ceiling while idle.
        act = 0;
        idle(1);
        @(posedge pclk);
        #1;
        force u_dut0.wr_cnt_q = 16'hFFFD;
        @(posedge pclk);
        #1;
        release u_dut0.wr_cnt_q;
        m_wr[0] = 65533;
        for (int i = 0; i < 3; i++) xfer(16'h8, 1'b1, $urandom);
        xfer(16'h4, 1'b0, 32'h0);
        xfer(16'h8, 1'b1, $urandom);
        xfer(16'h0, 1'b1, $urandom);
        xfer(16'h4, 1'b0, 32'h0);
        idle(4);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
